// File: rtl/alu_input_ctrl_pkg.sv
// Shared definitions for the ALU board input front-end: mode encodings and debounce defaults.
package alu_input_ctrl_pkg;

    localparam logic ST_SHOW_OPER = 1'b0;
    localparam logic ST_SHOW_RES  = 1'b1;

    localparam int unsigned DB_COUNT_DEFAULT = 1_000_000;
    localparam int unsigned CNT_W_DEFAULT    = 20;

    typedef enum logic {
        StShowOper = ST_SHOW_OPER,
        StShowRes  = ST_SHOW_RES
    } mode_e;

    typedef struct packed {
        logic [3:0] num1;
        logic [3:0] num2;
        logic [7:0] control;
    } operands_t;

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchroniser, stability counter and registered rising-edge strobe.
module btn_debounce
    import alu_input_ctrl_pkg::*;
#(
    parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = btn_i;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        // Any return to the accepted level restarts the count, so short glitches are dropped.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_COUNT - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        stable_dly_d = stable_q;
        pulse_d      = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_input_ctrl.sv
// Front-end for the ALU board: debounced button strobes drive the view FSM, the M bit and
// an operand snapshot that is shown while the result view is active.
module alu_input_ctrl
    import alu_input_ctrl_pkg::*;
#(
    parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    input  logic [3:0] Num1_in,
    input  logic [3:0] Num2_in,
    input  logic [7:0] Control_in,
    output logic       isResult,
    output logic       M,
    output logic [3:0] Num1,
    output logic [3:0] Num2,
    output logic [7:0] Control,
    output logic [3:0] btn_pulse
);

    logic [3:0] btn_raw;
    mode_e      state_q, state_d;
    logic       m_q, m_d;
    operands_t  snap_q, snap_d;

    assign btn_raw = {button4, button3, button2, button1};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DB_COUNT(DB_COUNT),
            .CNT_W   (CNT_W)
        ) u_db (
            .clk_i  (CLK),
            .rst_i  (RST),
            .btn_i  (btn_raw[i]),
            .pulse_o(btn_pulse[i])
        );
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        m_d     = m_q;
        // A result request wins over an operand request and always refreshes the snapshot.
        if (btn_pulse[0]) begin
            state_d = StShowRes;
            snap_d  = {Num1_in, Num2_in, Control_in};
        end else if (btn_pulse[1] && state_q == StShowRes) begin
            state_d = StShowOper;
        end
        if (btn_pulse[2]) begin
            m_d = 1'b1;
        end else if (btn_pulse[3]) begin
            m_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StShowOper;
            m_q     <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            snap_q  <= snap_d;
        end
    end

    assign isResult = (state_q == StShowRes);
    assign M        = m_q;
    assign Num1     = isResult ? snap_q.num1    : Num1_in;
    assign Num2     = isResult ? snap_q.num2    : Num2_in;
    assign Control  = isResult ? snap_q.control : Control_in;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Scoreboard bench for alu_input_ctrl with a short debounce window.
module tb_alu_input_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'h0;
    logic [3:0] n1_in = 4'h0;
    logic [3:0] n2_in = 4'h0;
    logic [7:0] ctl_in = 8'h00;
    logic       isResult, M;
    logic [3:0] Num1, Num2, btn_pulse;
    logic [7:0] Control;

    alu_input_ctrl #(
        .DB_COUNT(4),
        .CNT_W   (3)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .button1   (btn[0]),
        .button2   (btn[1]),
        .button3   (btn[2]),
        .button4   (btn[3]),
        .Num1_in   (n1_in),
        .Num2_in   (n2_in),
        .Control_in(ctl_in),
        .isResult  (isResult),
        .M         (M),
        .Num1      (Num1),
        .Num2      (Num2),
        .Control   (Control),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] pulse;
        int         at;     // expected cycle of the pulse, -1 = not timed
        logic       res;
        logic       m;
        logic [3:0] n1;
        logic [3:0] n2;
        logic [7:0] ctl;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   pending = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_press(input string name, input logic [3:0] p, input int at,
                                input logic res, input logic m, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] c);
        exp_t e;
        e.name = name; e.pulse = p; e.at = at; e.res = res; e.m = m;
        e.n1 = a; e.n2 = b; e.ctl = c;
        q.push_back(e);
    endtask

    // Hold buttons for 'hold' cycles, then release and let the release settle.
    task automatic press(input logic [3:0] b, input int hold);
        btn = btn | b;
        repeat (hold) @(negedge clk);
        btn = btn & ~b;
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every strobe pops one expectation; mode/operands are compared a cycle later.
    always @(negedge clk) begin
        if (pending) begin
            chk({cur.name, "/isResult"}, 32'(isResult), 32'(cur.res));
            chk({cur.name, "/M"}, 32'(M), 32'(cur.m));
            chk({cur.name, "/Num1"}, 32'(Num1), 32'(cur.n1));
            chk({cur.name, "/Num2"}, 32'(Num2), 32'(cur.n2));
            chk({cur.name, "/Control"}, 32'(Control), 32'(cur.ctl));
            pending = 1'b0;
        end
        if (btn_pulse != 4'h0) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(btn_pulse), 32'h0);
            end else begin
                cur = q.pop_front();
                chk({cur.name, "/pulse"}, 32'(btn_pulse), 32'(cur.pulse));
                if (cur.at >= 0) chk({cur.name, "/latency"}, 32'(cyc), 32'(cur.at));
                pending = 1'b1;
            end
        end
    end

    initial begin
        // 1: reset with all buttons held, then a held button1 after release
        btn = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst/isResult", 32'(isResult), 32'h0);
        chk("rst/M", 32'(M), 32'h0);
        chk("rst/btn_pulse", 32'(btn_pulse), 32'h0);
        chk("rst/Num1", 32'(Num1), 32'h0);
        chk("rst/Num2", 32'(Num2), 32'h0);
        chk("rst/Control", 32'(Control), 32'h0);
        expect_press("t1_b1", 4'b0001, cyc + 7, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00);
        btn = 4'b0001;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        btn = 4'h0;
        repeat (12) @(negedge clk);

        // 2: 3-cycle glitch is rejected; long hold gives exactly one strobe
        btn[2] = 1'b1;
        repeat (3) @(negedge clk);
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_glitch/M", 32'(M), 32'h0);
        expect_press("t2_b3", 4'b0100, -1, 1'b1, 1'b1, 4'h0, 4'h0, 8'h00);
        press(4'b0100, 30);

        // 3: snapshot holds while switches move; operand view shows live switches
        n1_in = 4'h3; n2_in = 4'h5; ctl_in = 8'h81;
        expect_press("t3_b1", 4'b0001, -1, 1'b1, 1'b1, 4'h3, 4'h5, 8'h81);
        press(4'b0001, 10);
        n1_in = 4'hF;
        @(negedge clk);
        chk("t3_hold/Num1", 32'(Num1), 32'h3);
        chk("t3_hold/Control", 32'(Control), 32'h81);
        expect_press("t3_b2", 4'b0010, -1, 1'b0, 1'b1, 4'hF, 4'h5, 8'h81);
        press(4'b0010, 10);
        chk("t3_live/Num1", 32'(Num1), 32'hF);

        // 4: simultaneous presses resolve by priority
        expect_press("t4_b12", 4'b0011, -1, 1'b1, 1'b1, 4'hF, 4'h5, 8'h81);
        press(4'b0011, 10);
        expect_press("t4_b4", 4'b1000, -1, 1'b1, 1'b0, 4'hF, 4'h5, 8'h81);
        press(4'b1000, 10);
        expect_press("t4_b34", 4'b1100, -1, 1'b1, 1'b1, 4'hF, 4'h5, 8'h81);
        press(4'b1100, 10);

        // 6: refresh in result view picks up new switch values
        n2_in = 4'h2;
        expect_press("t6_first", 4'b0001, -1, 1'b1, 1'b1, 4'hF, 4'h2, 8'h81);
        press(4'b0001, 10);
        n2_in = 4'h9;
        expect_press("t6_second", 4'b0001, -1, 1'b1, 1'b1, 4'hF, 4'h9, 8'h81);
        press(4'b0001, 10);

        // 5: asynchronous reset mid-count, button still held across release
        btn[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst/isResult", 32'(isResult), 32'h0);
        chk("t5_rst/M", 32'(M), 32'h0);
        chk("t5_rst/btn_pulse", 32'(btn_pulse), 32'h0);
        chk("t5_rst/Num2", 32'(Num2), 32'h9);
        @(negedge clk);
        @(negedge clk);
        expect_press("t5_held", 4'b0001, cyc + 7, 1'b1, 1'b0, 4'hF, 4'h9, 8'h81);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);

        chk("missing_pulses", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
